// File: rtl/mux_rr_arb.sv
// N-input registered multiplexer with per-channel valid/ready handshake.
// Selects by round-robin across valid inputs (mode=0) or by an external index (mode=1).
module mux_rr_arb #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  int               rr_idx;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin scan runs from the far end back to ptr so the last hit is the first in search order.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    if (load_en) begin
      if (mode) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (sel == SEL_W'(i) && in_valid[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(i);
          end
        end
      end else begin
        for (int k = NUM_IN - 1; k >= 0; k--) begin
          rr_idx = int'(ptr_q) + k;
          if (rr_idx >= NUM_IN) rr_idx = rr_idx - NUM_IN;
          if (in_valid[SEL_W'(rr_idx)]) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(rr_idx);
          end
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign in_ready = (rst_n && gnt_vld) ? (NUM_IN'(1) << gnt_idx) : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (gnt_vld) begin
      out_data_d  = gnt_data;
      out_chan_d  = gnt_idx;
      out_valid_d = 1'b1;
      if (!mode) begin
        ptr_d = (int'(gnt_idx) == NUM_IN - 1) ? '0 : gnt_idx + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench for mux_rr_arb: an 8-input and a 5-input instance share clock and reset.
module tb_mux_rr_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_mode, a_out_ready, a_out_valid;
  logic [2:0]  a_sel, a_out_chan;
  logic [63:0] a_in_data;
  logic [7:0]  a_in_valid, a_in_ready, a_out_data;

  logic        b_mode, b_out_ready, b_out_valid;
  logic [2:0]  b_sel, b_out_chan;
  logic [39:0] b_in_data;
  logic [4:0]  b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;

  mux_rr_arb #(.WIDTH(8), .NUM_IN(8)) u_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_chan(a_out_chan), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  mux_rr_arb #(.WIDTH(8), .NUM_IN(5)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_chan(b_out_chan), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Words are consumed at the posedge following a negedge where valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) chk("a_unexpected_word", {21'd0, a_out_chan, a_out_data}, 32'hFFFF);
      else chk("a_word", {21'd0, a_out_chan, a_out_data}, {21'd0, exp_a.pop_front()});
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) chk("b_unexpected_word", {21'd0, b_out_chan, b_out_data}, 32'hFFFF);
      else chk("b_word", {21'd0, b_out_chan, b_out_data}, {21'd0, exp_b.pop_front()});
    end
  end

  initial begin
    a_mode = 1'b0; a_sel = '0; a_in_valid = '0; a_out_ready = 1'b1;
    b_mode = 1'b0; b_sel = '0; b_in_valid = '0; b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 5; i++) b_in_data[i*8 +: 8] = 8'h20 + 8'(i);

    // reset: ready must stay low even with valid inputs
    a_in_valid = 8'hFF;
    #12;
    chk("rst_in_ready", {24'd0, a_in_ready}, 32'h0);
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'h0);
    chk("rst_out_data", {24'd0, a_out_data}, 32'h0);
    chk("rst_out_chan", {29'd0, a_out_chan}, 32'h0);
    a_in_valid = '0;
    #5 rst_n = 1'b1;
    cyc();

    // fixed select sel=5
    a_mode = 1'b1; a_sel = 3'd5; a_in_valid = 8'hFF;
    #1 chk("fixed_in_ready", {24'd0, a_in_ready}, 32'h20);
    exp_a.push_back({3'd5, 8'h15});
    cyc();
    chk("fixed_out_valid", {31'd0, a_out_valid}, 32'h1);

    // round-robin, all valid: 0..7,0,1 back to back (ptr still 0 after fixed grant)
    a_mode = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1 chk("rr_in_ready", {24'd0, a_in_ready}, 32'(8'h01 << (k % 8)));
      exp_a.push_back({3'(k % 8), 8'h10 + 8'(k % 8)});
      cyc();
      chk("rr_no_bubble", {31'd0, a_out_valid}, 32'h1);
    end

    // ptr=2: grant channel 2 alone -> ptr=3, then 7, 2, 7
    a_in_valid = 8'b0000_0100;
    #1 chk("setup_in_ready", {24'd0, a_in_ready}, 32'h04);
    exp_a.push_back({3'd2, 8'h12});
    cyc();
    a_in_valid = 8'b1000_0100;
    #1 chk("skip_g7", {24'd0, a_in_ready}, 32'h80);
    exp_a.push_back({3'd7, 8'h17});
    cyc();
    #1 chk("wrap_g2", {24'd0, a_in_ready}, 32'h04);
    exp_a.push_back({3'd2, 8'h12});
    cyc();
    #1 chk("skip_g7b", {24'd0, a_in_ready}, 32'h80);
    exp_a.push_back({3'd7, 8'h17});
    cyc();
    a_in_valid = '0;
    cyc();
    chk("drained", {31'd0, a_out_valid}, 32'h0);

    // backpressure: load A5 on channel 3 (ptr=0), then stall 4 cycles
    a_in_data[3*8 +: 8] = 8'hA5;
    a_in_valid = 8'b0000_1000;
    exp_a.push_back({3'd3, 8'hA5});
    cyc();
    a_out_ready = 1'b0;
    a_in_valid = 8'b1000_0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_in_ready", {24'd0, a_in_ready}, 32'h0);
      chk("bp_out_data", {24'd0, a_out_data}, 32'hA5);
      chk("bp_out_valid", {31'd0, a_out_valid}, 32'h1);
      cyc();
    end
    a_out_ready = 1'b1;
    #1 chk("bp_release_ready", {24'd0, a_in_ready}, 32'h80);
    exp_a.push_back({3'd7, 8'h17});
    cyc();
    chk("bp_release_chan", {29'd0, a_out_chan}, 32'h7);
    a_in_valid = '0;
    cyc();

    // async reset while FULL with channel 5 (ptr would become 6)
    a_out_ready = 1'b0;
    a_in_valid = 8'b0010_0000;
    cyc();
    a_in_valid = '0;
    chk("pre_rst_valid", {31'd0, a_out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, a_out_valid}, 32'h0);
    chk("arst_out_data", {24'd0, a_out_data}, 32'h0);
    chk("arst_out_chan", {29'd0, a_out_chan}, 32'h0);
    #1 rst_n = 1'b1;
    cyc();
    a_out_ready = 1'b1;
    a_in_valid = 8'hFF;
    #1 chk("post_rst_ptr0", {24'd0, a_in_ready}, 32'h01);
    exp_a.push_back({3'd0, 8'h10});
    cyc();
    a_in_valid = '0;
    cyc();

    // 5-input instance: out-of-range sel never grants
    b_mode = 1'b1; b_sel = 3'd6; b_in_valid = 5'b11111;
    for (int k = 0; k < 2; k++) begin
      #1 chk("b_sel_oor_ready", {27'd0, b_in_ready}, 32'h0);
      cyc();
      chk("b_sel_oor_valid", {31'd0, b_out_valid}, 32'h0);
    end
    b_mode = 1'b0; b_in_valid = 5'b10000;
    #1 chk("b_g4", {27'd0, b_in_ready}, 32'h10);
    exp_b.push_back({3'd4, 8'h24});
    cyc();
    b_in_valid = 5'b11111;
    #1 chk("b_wrap_g0", {27'd0, b_in_ready}, 32'h01);
    exp_b.push_back({3'd0, 8'h20});
    cyc();
    b_in_valid = '0;
    cyc();
    cyc();

    chk("a_queue_empty", 32'(exp_a.size()), 32'h0);
    chk("b_queue_empty", 32'(exp_b.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
- Parametrised N-input, WIDTH-bit multiplexer with a valid/ready handshake on every input and a registered output.
- Two selection modes: round-robin arbitration across valid inputs, or fixed selection by an external select field, as in the existing 8:1 mux.
- Sits between multiple producers and one consumer, replacing the combinational mux wherever backpressure or fairness is needed.

Parameters:
WIDTH, 8, data width per channel
NUM_IN, 8, number of input channels (2..32, need not be a power of two)
SEL_W, $clog2(NUM_IN), localparam: width of sel and out_chan

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = round-robin, 1 = fixed select
sel  input  SEL_W  channel index used when mode=1
in_data  input  NUM_IN*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_IN  per-channel valid
in_ready  output  NUM_IN  per-channel ready (one-hot or zero)
out_data  output  WIDTH  registered selected data
out_chan  output  SEL_W  index of the channel that supplied out_data
out_valid  output  1  output holds a word
out_ready  input  1  consumer accepts the word

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 combinationally while in reset.
- Output stage has two states.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - load_en = !out_valid || out_ready. This is combinational and gives full throughput, one word per cycle.
- Grant (combinational, only when load_en=1):
  - mode=0: grant the first i with in_valid[i]=1, searching ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1.
  - mode=1: grant sel if sel<NUM_IN and in_valid[sel]=1. Otherwise no grant.
  - Any sel ≥ NUM_IN never grants and never reads out of range.
- in_ready[g]=1 only for the granted channel g; all other bits are 0. If load_en=0 or there is no grant, in_ready is all zeros.
- Transfer on an input occurs when in_valid[i] && in_ready[i]. On that clock edge:
  - out_data ← channel g data, out_chan ← g, out_valid ← 1.
  - If mode=0, ptr ← (g+1) mod NUM_IN, with an explicit wrap for non-power-of-two NUM_IN.
  - If mode=1, ptr is unchanged.
- Output handshake:
  - If out_valid && out_ready and there is no new grant, out_valid ← 0 and out_data/out_chan hold their last value.
  - Simultaneous drain and load goes FULL→FULL with the new word. No bubble.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold stable, and in_ready is all zeros.
- Latency: 1 cycle from input transfer to out_valid.
- mode and sel are sampled in the same cycle as the grant. A mode change never affects a word already in the output register.
- A producer may drop in_valid without a transfer; the block must not latch that channel.
- Reset asserted mid-transfer discards the word in the output register and returns to EMPTY with ptr=0.

Test Plan:
- Fixed mode, NUM_IN=8, WIDTH=8, mode=1, sel=5, all inputs valid, in_data[i]=8'h10+i, out_ready=1 -> in_ready=8'b0010_0000; next cycle out_data=8'h15, out_chan=5, out_valid=1; ptr stays 0.
- Round-robin fairness, mode=0, all 8 inputs valid continuously, out_ready=1 -> out_chan sequence 0,1,2,…,7,0,1 on consecutive cycles with no idle cycles.
- Skipping and wrap, mode=0, in_valid=8'b1000_0100, ptr=3 -> grants 7 first, then 2, then 7; ptr goes 0→3 (setup) →0 (after 7) →3 (after 2).
- Backpressure, out_ready=0 for 4 cycles after a load of 8'hA5 -> out_data stays 8'hA5 and out_valid=1 throughout; in_ready=0; on out_ready=1 the next word loads in the same cycle.
- Non-power-of-two, NUM_IN=5, mode=1, sel=6 with all inputs valid -> no grant and out_valid stays 0. Then mode=0 with only in_valid[4] set -> grant 4, ptr wraps to 0.
- Async reset, rst_n pulled low mid-cycle while FULL -> out_valid, out_data and out_chan go to 0 immediately without a clock edge; after release the first grant starts from ptr=0.
